// File: rtl/s820_bist_pkg.sv
// Shared types, widths and polynomial taps for the s820 BIST sequencer.
package s820_bist_pkg;

  localparam int PI_W   = 17;
  localparam int PO_W   = 19;
  localparam int CNT_W  = 16;
  localparam int RCNT_W = 4;

  // LFSR x^17 + x^14 + 1: feedback from bits 16 and 13, shifted in at bit 0.
  localparam int LFSR_TAP_A = 16;
  localparam int LFSR_TAP_B = 13;

  // MISR x^19 + x^5 + x^2 + x + 1: feedback from bits 18, 4, 1, 0.
  localparam logic [PO_W-1:0] MISR_TAPS = 19'h40013;

  // Core PO to MISR bit mapping.
  localparam int PO_G288 = 0;
  localparam int PO_G290 = 1;
  localparam int PO_G292 = 2;
  localparam int PO_G296 = 3;
  localparam int PO_G298 = 4;
  localparam int PO_G300 = 5;
  localparam int PO_G302 = 6;
  localparam int PO_G310 = 7;
  localparam int PO_G312 = 8;
  localparam int PO_G315 = 9;
  localparam int PO_G322 = 10;
  localparam int PO_G325 = 11;
  localparam int PO_G327 = 12;
  localparam int PO_G43  = 13;
  localparam int PO_G45  = 14;
  localparam int PO_G47  = 15;
  localparam int PO_G49  = 16;
  localparam int PO_G53  = 17;
  localparam int PO_G55  = 18;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_CUT = 3'd1,
    ST_RUN     = 3'd2,
    ST_SIGN    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] v);
    return {v[PI_W-2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
  endfunction

  function automatic logic [PO_W-1:0] misr_next(input logic [PO_W-1:0] m,
                                                input logic [PO_W-1:0] d);
    logic fb;
    fb = ^(m & MISR_TAPS);
    return {m[PO_W-2:0], fb} ^ d;
  endfunction

endpackage

// File: rtl/s820_bist_ctrl_if.sv
// Bundle between the chip test controller / s820 core and the BIST sequencer.
// master = test controller plus core side, slave = BIST sequencer.
interface s820_bist_ctrl_if;
  import s820_bist_pkg::*;

  logic            start;
  logic            abort;
  logic [PI_W-1:0] cut_pi;
  logic            cut_rst;
  logic [PO_W-1:0] cut_po;
  logic            busy;
  logic            done;
  logic            pass;
  logic [PO_W-1:0] signature;

  modport master (
    output start, abort, cut_po,
    input  cut_pi, cut_rst, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, cut_po,
    output cut_pi, cut_rst, busy, done, pass, signature
  );

endinterface

// File: rtl/s820_bist_misr.sv
// Multiple-input signature register compacting the core responses.
// clr has priority over en so a fresh run always starts from zero.
module s820_bist_misr
  import s820_bist_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            en,
  input  logic            clr,
  input  logic [PO_W-1:0] data,
  output logic [PO_W-1:0] sig
);

  logic [PO_W-1:0] misr_q;

  // Signature register: sync clear, otherwise fold one response per enabled edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      misr_q <= '0;
    end else if (clr) begin
      misr_q <= '0;
    end else if (en) begin
      misr_q <= misr_next(misr_q, data);
    end
  end

  assign sig = misr_q;

endmodule

// File: rtl/s820_bist_ctrl.sv
// BIST sequencer for the s820 core: clear core state, apply N_PAT LFSR
// vectors, compact responses in a MISR and compare against GOLDEN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start, core inputs parked on the LFSR seed
// ST_RST_CUT | G18 held high for RST_CYC cycles to clear the core flops
// ST_RUN     | one vector per cycle, response captured at the retiring edge
// ST_SIGN    | one cycle to register the signature compare
// ST_DONE    | result held until the next start
module s820_bist_ctrl
  import s820_bist_pkg::*;
#(
  parameter int unsigned      N_PAT   = 1024,
  parameter int unsigned      RST_CYC = 2,
  parameter logic [PI_W-1:0]  SEED    = 17'h00001,
  parameter logic [PO_W-1:0]  GOLDEN  = 19'h00000
) (
  input  logic            CK,
  input  logic            RSTN,
  s820_bist_ctrl_if.slave bus
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [PI_W-1:0]   SEED_EFF = (SEED == '0) ? PI_W'(1) : SEED;
  localparam logic [CNT_W-1:0]  PAT_LAST = CNT_W'(N_PAT - 1);
  localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYC - 1);

  state_t            state_q;
  state_t            state_d;
  logic [PI_W-1:0]   lfsr_q;
  logic [CNT_W-1:0]  pat_cnt_q;
  logic [RCNT_W-1:0] rst_cnt_q;
  logic              pass_q;
  logic [PO_W-1:0]   misr_sig;

  logic              run_load;
  logic              rst_dec;
  logic              vec_step;
  logic              pass_upd;
  logic              pass_clr;

  // State register.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; abort beats any busy-state transition.
  always_comb begin
    state_d  = state_q;
    run_load = 1'b0;
    rst_dec  = 1'b0;
    vec_step = 1'b0;
    pass_upd = 1'b0;
    pass_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_RST_CUT;
          run_load = 1'b1;
          pass_clr = 1'b1;
        end
      end
      ST_RST_CUT: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          pass_clr = 1'b1;
        end else if (rst_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rst_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          pass_clr = 1'b1;
        end else begin
          vec_step = 1'b1;
          if (pat_cnt_q == PAT_LAST) begin
            state_d = ST_SIGN;
          end
        end
      end
      ST_SIGN: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          pass_clr = 1'b1;
        end else begin
          state_d  = ST_DONE;
          pass_upd = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pass_clr = 1'b1;
      end
    endcase
  end

  // Pattern generator: reloaded on start, advanced once per applied vector.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      lfsr_q <= SEED_EFF;
    end else if (run_load) begin
      lfsr_q <= SEED_EFF;
    end else if (vec_step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Applied-vector counter; its terminal value marks the last capture.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      pat_cnt_q <= '0;
    end else if (run_load) begin
      pat_cnt_q <= '0;
    end else if (vec_step) begin
      pat_cnt_q <= pat_cnt_q + CNT_W'(1);
    end
  end

  // Core-clear down-counter; reaching zero ends the G18 pulse.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      rst_cnt_q <= '0;
    end else if (run_load) begin
      rst_cnt_q <= RST_LAST;
    end else if (rst_dec) begin
      rst_cnt_q <= rst_cnt_q - RCNT_W'(1);
    end
  end

  // Pass flag: set from the final signature, cleared on start or abort.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      pass_q <= 1'b0;
    end else if (pass_clr) begin
      pass_q <= 1'b0;
    end else if (pass_upd) begin
      pass_q <= (misr_sig == GOLDEN);
    end
  end

  // The MISR only folds while vectors are being retired, so an abort freezes it.
  s820_bist_misr u_misr (
    .clk   (CK),
    .rst_b (RSTN),
    .en    (vec_step),
    .clr   (run_load),
    .data  (bus.cut_po),
    .sig   (misr_sig)
  );

  assign bus.cut_pi    = lfsr_q;
  assign bus.cut_rst   = (state_q == ST_RST_CUT);
  assign bus.busy      = (state_q == ST_RST_CUT) || (state_q == ST_RUN) ||
                         (state_q == ST_SIGN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = misr_sig;

endmodule
